// File: rtl/tt_sweep_capture_if.sv
// Signal bundle between the sweep capture block and the function-under-test harness.
// slave = capture block side, master = stimulus/harness side.
interface tt_sweep_capture_if;
  logic        start;
  logic        f_in;
  logic        w;
  logic        x;
  logic        y;
  logic        z;
  logic        busy;
  logic        done;
  logic [15:0] truth;
  logic [4:0]  ones_cnt;
  logic [4:0]  err_cnt;
  logic        pass;

  modport slave (
    input  start,
    input  f_in,
    output w,
    output x,
    output y,
    output z,
    output busy,
    output done,
    output truth,
    output ones_cnt,
    output err_cnt,
    output pass
  );

  modport master (
    output start,
    output f_in,
    input  w,
    input  x,
    input  y,
    input  z,
    input  busy,
    input  done,
    input  truth,
    input  ones_cnt,
    input  err_cnt,
    input  pass
  );
endinterface

// File: rtl/tt_sweep_capture.sv
// Walks {w,x,y,z} through all 16 vectors, samples f_in after SETTLE cycles per vector,
// and grades the captured truth table against EXPECT; done after 16*(SETTLE+1) cycles.
module tt_sweep_capture #(
  parameter int unsigned SETTLE = 2,
  parameter logic [15:0] EXPECT = 16'h1F55
) (
  input  logic               clk,
  input  logic               rst_n,
  tt_sweep_capture_if.slave  bus
);

  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("tt_sweep_capture: SETTLE must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q,   idx_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [15:0] truth_q, truth_d;
  logic [4:0]  ones_q,  ones_d;
  logic [4:0]  err_q,   err_d;

  logic        active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      truth_q <= 16'd0;
      ones_q  <= 5'd0;
      err_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      truth_q <= truth_d;
      ones_q  <= ones_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    truth_d = truth_q;
    ones_d  = ones_q;
    err_d   = err_q;

    unique case (state_q)
      // DONE accepts start exactly like IDLE so a finished sweep can be rerun.
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_SETTLE;
          idx_d   = 4'd0;
          cnt_d   = 4'd0;
          truth_d = 16'd0;
          ones_d  = 5'd0;
          err_d   = 5'd0;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end

      ST_SAMPLE: begin
        truth_d[idx_q] = bus.f_in;
        ones_d         = ones_q + {4'd0, bus.f_in};
        err_d          = err_q + {4'd0, bus.f_in ^ EXPECT[idx_q]};
        if (idx_q == 4'hF) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETTLE;
          idx_d   = idx_q + 4'd1;
          cnt_d   = 4'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state so reset clears them without a clock.
  assign active       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign bus.w        = active & idx_q[3];
  assign bus.x        = active & idx_q[2];
  assign bus.y        = active & idx_q[1];
  assign bus.z        = active & idx_q[0];
  assign bus.busy     = active;
  assign bus.done     = (state_q == ST_DONE);
  assign bus.truth    = truth_q;
  assign bus.ones_cnt = ones_q;
  assign bus.err_cnt  = err_q;
  assign bus.pass     = (state_q == ST_DONE) && (err_q == 5'd0);

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: a behavioural function model drives f_in, expected sweep
// results are queued at start and compared when done rises.
module tb_tt_sweep_capture;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tt_sweep_capture_if bus_a ();
  tt_sweep_capture_if bus_b ();

  tt_sweep_capture #(.SETTLE(2), .EXPECT(16'h1F55)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  tt_sweep_capture #(.SETTLE(1), .EXPECT(16'h1F55)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    logic [15:0] truth;
    logic [4:0]  ones;
    logic [4:0]  err;
    logic        pass;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   mode   = 0;   // 0: function model, 1: stuck-at-0, 2: stuck-at-1

  function automatic logic f_ref(input logic [3:0] v);
    logic w, x, y, z;
    {w, x, y, z} = v;
    return (w & ~x) | (~y & ~z) | (~w & ~z);
  endfunction

  always_comb begin
    case (mode)
      1:       bus_a.f_in = 1'b0;
      2:       bus_a.f_in = 1'b1;
      default: bus_a.f_in = f_ref({bus_a.w, bus_a.x, bus_a.y, bus_a.z});
    endcase
  end
  assign bus_b.f_in = 1'b1;

  task automatic push_expected(input int m, input int settle);
    exp_t e;
    for (int i = 0; i < 16; i++)
      e.truth[i] = (m == 0) ? f_ref(4'(i)) : (m == 2);
    e.ones = 5'($countones(e.truth));
    e.err  = 5'($countones(e.truth ^ 16'h1F55));
    e.pass = (e.err == 5'd0);
    e.lat  = 16 * (settle + 1);
    sb.push_back(e);
  endtask

  task automatic check_results(input string tag, input int lat, input logic [15:0] truth,
                               input logic [4:0] ones, input logic [4:0] err, input logic pass);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++; n_fail++;
      $display("FAIL %s scoreboard_empty", tag);
      return;
    end
    e = sb.pop_front();
    n_vec++;
    if (lat !== e.lat) begin
      n_fail++; $display("FAIL %s latency got %0d want %0d", tag, lat, e.lat);
    end
    n_vec++;
    if (truth !== e.truth) begin
      n_fail++; $display("FAIL %s truth got %h want %h", tag, truth, e.truth);
    end
    n_vec++;
    if (ones !== e.ones) begin
      n_fail++; $display("FAIL %s ones_cnt got %0d want %0d", tag, ones, e.ones);
    end
    n_vec++;
    if (err !== e.err) begin
      n_fail++; $display("FAIL %s err_cnt got %0d want %0d", tag, err, e.err);
    end
    n_vec++;
    if (pass !== e.pass) begin
      n_fail++; $display("FAIL %s pass got %b want %b", tag, pass, e.pass);
    end
  endtask

  // One sweep on dut_a; optionally checks per-cycle vector stepping and pokes start at vector 5.
  task automatic run_a(input string tag, input int m, input bit check_vec, input bit poke_start);
    int n;
    bit seen;
    logic [3:0] v;
    mode = m;
    @(negedge clk);
    bus_a.start = 1'b1;
    push_expected(m, 2);
    @(negedge clk);
    bus_a.start = 1'b0;
    n_vec++;
    if (bus_a.busy !== 1'b1 || bus_a.done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start_accept busy=%b done=%b want busy=1 done=0", tag, bus_a.busy, bus_a.done);
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      if (check_vec && n < 48) begin
        v = {bus_a.w, bus_a.x, bus_a.y, bus_a.z};
        n_vec++;
        if (v !== 4'(n / 3) || bus_a.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s vec_cycle%0d got %h busy=%b want %h busy=1", tag, n, v, bus_a.busy, 4'(n / 3));
        end
      end
      bus_a.start = poke_start && (n == 16);
      @(negedge clk);
      n++;
      seen = bus_a.done;
    end
    bus_a.start = 1'b0;
    if (!seen) begin
      n_vec++; n_fail++;
      $display("FAIL %s done_timeout after %0d cycles", tag, n);
    end
    check_results(tag, n, bus_a.truth, bus_a.ones_cnt, bus_a.err_cnt, bus_a.pass);
    n_vec++;
    if ({bus_a.w, bus_a.x, bus_a.y, bus_a.z, bus_a.busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL %s done_state wxyz=%b%b%b%b busy=%b want 0", tag,
               bus_a.w, bus_a.x, bus_a.y, bus_a.z, bus_a.busy);
    end
  endtask

  task automatic test_reset;
    logic [43:0] all_a, all_b;
    rst_n = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    #2;
    all_a = {bus_a.w, bus_a.x, bus_a.y, bus_a.z, bus_a.busy, bus_a.done, bus_a.pass,
             bus_a.truth, bus_a.ones_cnt, bus_a.err_cnt, 7'd0};
    all_b = {bus_b.w, bus_b.x, bus_b.y, bus_b.z, bus_b.busy, bus_b.done, bus_b.pass,
             bus_b.truth, bus_b.ones_cnt, bus_b.err_cnt, 7'd0};
    n_vec++;
    if (all_a !== 44'd0 || all_b !== 44'd0) begin
      n_fail++; $display("FAIL reset_values a=%h b=%h want 0", all_a, all_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_vec++;
    if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 || bus_b.busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_wait busy_a=%b done_a=%b busy_b=%b want 0", bus_a.busy, bus_a.done, bus_b.busy);
    end
  endtask

  task automatic test_model_sweep;
    run_a("model_sweep", 0, 1'b1, 1'b1);
  endtask

  task automatic test_stuck0;
    run_a("stuck0", 1, 1'b0, 1'b0);
  endtask

  task automatic test_stuck1;
    int n;
    bit seen;
    @(negedge clk);
    bus_b.start = 1'b1;
    push_expected(2, 1);
    @(negedge clk);
    bus_b.start = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      seen = bus_b.done;
    end
    if (!seen) begin
      n_vec++; n_fail++;
      $display("FAIL stuck1 done_timeout after %0d cycles", n);
    end
    check_results("stuck1", n, bus_b.truth, bus_b.ones_cnt, bus_b.err_cnt, bus_b.pass);
  endtask

  task automatic test_reset_mid;
    int n;
    logic [15:0] part;
    logic [43:0] all_a;
    mode = 0;
    @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    n = 0;
    while ({bus_a.w, bus_a.x, bus_a.y, bus_a.z} != 4'd9 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if ({bus_a.w, bus_a.x, bus_a.y, bus_a.z} !== 4'd9) begin
      n_fail++; $display("FAIL reset_mid reach_vec9 got %b%b%b%b want 1001", bus_a.w, bus_a.x, bus_a.y, bus_a.z);
    end
    for (int i = 0; i < 16; i++) part[i] = (i < 9) ? f_ref(4'(i)) : 1'b0;
    n_vec++;
    if (bus_a.truth !== part || bus_a.ones_cnt !== 5'($countones(part))) begin
      n_fail++;
      $display("FAIL partial_truth got %h/%0d want %h/%0d", bus_a.truth, bus_a.ones_cnt, part, $countones(part));
    end
    #2 rst_n = 1'b0;
    #1;
    all_a = {bus_a.w, bus_a.x, bus_a.y, bus_a.z, bus_a.busy, bus_a.done, bus_a.pass,
             bus_a.truth, bus_a.ones_cnt, bus_a.err_cnt, 7'd0};
    n_vec++;
    if (all_a !== 44'd0) begin
      n_fail++; $display("FAIL async_reset got %h want 0", all_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++;
    if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 || bus_a.truth !== 16'd0) begin
      n_fail++; $display("FAIL post_reset_idle busy=%b done=%b truth=%h want 0", bus_a.busy, bus_a.done, bus_a.truth);
    end
    run_a("after_reset", 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    // dut_a sits in DONE here; a new start must restart it.
    n_vec++;
    if (bus_a.done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_precondition done=%b want 1", bus_a.done);
    end
    run_a("restart_from_done", 0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_model_sweep();
    test_stuck0();
    test_stuck1();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_sweep_capture.md
TT_SWEEP_CAPTURE -- requirements
Module: tt_sweep_capture

Interface
REQ-001 Parameter SETTLE, default 2: cycles each input vector is held before F is sampled; legal range 1..15.
REQ-002 Parameter EXPECT, default 16'h1F55: golden truth table of the downstream function, bit i = F for vector i.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a full 16-vector sweep; sampled on the rising edge of clk.
REQ-006 w, x, y, z  output  1 each  drive the function-under-test inputs; {w,x,y,z} = vector index, w MSB.
REQ-007 f_in  input  1  output F of the function-under-test.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  high after sweep completion; held until the next accepted start or reset.
REQ-010 truth  output  16  captured F values; bit i = F sampled for vector i.
REQ-011 ones_cnt  output  5  number of vectors for which F sampled 1 (0..16).
REQ-012 err_cnt  output  5  number of bits where truth differs from EXPECT; valid when done=1.
REQ-013 pass  output  1  high when done=1 and err_cnt=0.

Function
REQ-014 FSM states: IDLE, SETTLE, SAMPLE, DONE.
REQ-015 IDLE: start=1 -> SETTLE. On that edge, idx=0, settle counter=0, truth=0, ones_cnt=0, err_cnt=0, busy=1, done=0.
REQ-016 DONE: start=1 -> SETTLE, with the same initialisation as REQ-015. This is a restart.
REQ-017 SETTLE: {w,x,y,z}=idx. Counter increments each cycle. The FSM stays in SETTLE exactly SETTLE cycles, then -> SAMPLE.
REQ-018 SAMPLE: lasts 1 cycle, with {w,x,y,z}=idx still driven.
REQ-019 At the end of SAMPLE: truth[idx]<=f_in; ones_cnt += f_in; err_cnt += (f_in != EXPECT[idx]).
REQ-020 After SAMPLE: if idx=15 -> DONE; else idx+1 and -> SETTLE with counter cleared.
REQ-021 Vector index wraps never; the sweep terminates at idx=15 and does not roll to 0.
REQ-022 Each vector occupies SETTLE+1 cycles.
REQ-023 Latency: start accepted at edge k gives done=1 after edge k+16*(SETTLE+1); with default SETTLE, 48 cycles.
REQ-024 start while busy=1 is ignored; no restart and no state change.
REQ-025 DONE: busy=0, done=1, {w,x,y,z}=0000. truth, ones_cnt and err_cnt hold. pass=(err_cnt==0).
REQ-026 IDLE: {w,x,y,z}=0000, busy=0, done=0, pass=0.
REQ-027 truth bits for vectors not yet sampled read 0 during a sweep.
REQ-028 ones_cnt and err_cnt are 5-bit and cannot overflow, maximum 16.

Reset
REQ-029 rst_n=0 immediately forces, independent of clk: state=IDLE, idx=0, counter=0, w=x=y=z=0, busy=0, done=0, truth=0, ones_cnt=0, err_cnt=0, pass=0.
REQ-030 Reset asserted mid-sweep aborts the sweep; all partial results are discarded.
REQ-031 After rst_n deasserts, the block waits in IDLE for start; no sweep begins without start.

Verification
REQ-032 Correct function: f_in driven by a model F = w·x' + y'·z' + w'·z', default params, start pulse -> done after 48 cycles, truth=16'h1F55, ones_cnt=9, err_cnt=0, pass=1.
REQ-033 Stuck-at-0: f_in tied 0 -> truth=16'h0000, ones_cnt=0, err_cnt=9, pass=0.
REQ-034 Stuck-at-1: f_in tied 1, SETTLE=1 -> done after 32 cycles, truth=16'hFFFF, ones_cnt=16, err_cnt=7, pass=0.
REQ-035 Vector timing: {w,x,y,z} steps 0000, 0001 .. 1111, each held 3 cycles (SETTLE=2). A start pulse at vector 5 is ignored; truth is unchanged versus REQ-032.
REQ-036 Reset mid-sweep and restart:
- rst_n pulsed low during vector 9 -> all outputs 0 asynchronously, before the next clk edge.
- A following start yields a full clean sweep matching REQ-032.
- A second start while in DONE restarts the sweep, with done=0 on the next edge.
